// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR accumulator back end
package fir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fir_acc_state_t;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Shared with the coefficient memory so both agree on tap count and Q format.
  localparam int DEF_TAPS  = 8;
  localparam int DEF_SHIFT = 15;
  localparam int DEF_ACC_W = 40;

  function automatic int unsigned cnt_width(input int unsigned taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_accumulator_if.sv
// rtl/fir_accumulator_if.sv - product input stream and sample output stream
interface fir_accumulator_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up, arithmetic scale by SHIFT, clip to 32 bits
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [ACC_W-1:0] total_i,
  output logic [31:0]      data_o,
  output logic             sat_o
);

  localparam int RW = ACC_W + 1;

  // Half an output LSB; shifting the one back down makes SHIFT = 0 yield zero.
  localparam logic [RW-1:0] RND   = (RW'(1) << SHIFT) >> 1;
  localparam logic [RW-1:0] Q_MAX = {{(RW-32){1'b0}}, SAT_MAX};
  localparam logic [RW-1:0] Q_MIN = {{(RW-32){1'b1}}, SAT_MIN};

  logic signed [RW-1:0] r_w;
  logic signed [RW-1:0] q_w;

  always_comb begin
    r_w    = $signed({total_i[ACC_W-1], total_i}) + $signed(RND);
    q_w    = r_w >>> SHIFT;
    data_o = q_w[31:0];
    sat_o  = 1'b0;
    if (q_w > $signed(Q_MAX)) begin
      data_o = SAT_MAX;
      sat_o  = 1'b1;
    end else if (q_w < $signed(Q_MIN)) begin
      data_o = SAT_MIN;
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_accumulator.sv
// rtl/fir_accumulator.sv - sums TAPS products per sample into a one-entry output register
module fir_accumulator
  import fir_pkg::*;
#(
  parameter int TAPS  = DEF_TAPS,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  fir_accumulator_if.slave   bus
);

  localparam int CNT_W = cnt_width(TAPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  fir_acc_state_t   state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] tap_cnt_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             out_sat_q;

  logic             last_beat_w;
  logic             in_ready_w;
  logic             accept_w;
  logic [ACC_W-1:0] in_sext_w;
  logic [ACC_W-1:0] total_d;
  logic [31:0]      rs_data_d;
  logic             rs_sat_d;

  assign last_beat_w = (tap_cnt_q == LAST_CNT);
  // Only the closing beat needs the output slot, so only it waits on backpressure.
  assign in_ready_w  = !clear && !(last_beat_w && out_valid_q && !bus.out_ready);
  assign accept_w    = bus.in_valid && in_ready_w;
  assign in_sext_w   = {{(ACC_W-32){bus.in_data[31]}}, bus.in_data};
  assign total_d     = acc_q + in_sext_w;

  fir_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .total_i (total_d),
    .data_o  (rs_data_d),
    .sat_o   (rs_sat_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (clear) begin
        state_q   <= IDLE;
        acc_q     <= '0;
        tap_cnt_q <= '0;
      end else if (accept_w) begin
        unique case (state_q)
          IDLE: begin
            acc_q     <= in_sext_w;
            tap_cnt_q <= CNT_W'(1);
            state_q   <= ACCUM;
          end
          ACCUM: begin
            if (last_beat_w) begin
              // Drain and refill may coincide; this write wins over the clear above.
              out_data_q  <= rs_data_d;
              out_sat_q   <= rs_sat_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              tap_cnt_q   <= '0;
              state_q     <= IDLE;
            end else begin
              acc_q     <= total_d;
              tap_cnt_q <= tap_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            acc_q     <= '0;
            tap_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_accumulator.sv
// tb/tb_fir_accumulator.sv - directed bench for fir_accumulator at TAPS=4/SHIFT=0 and TAPS=2/SHIFT=15
module tb_fir_accumulator;

  logic clk;
  logic reset_n;
  logic clear;
  int   checks;
  int   errors;

  fir_accumulator_if b4 ();
  fir_accumulator_if b2 ();

  fir_accumulator #(.TAPS(4), .ACC_W(40), .SHIFT(0)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (b4.slave)
  );

  fir_accumulator #(.TAPS(2), .ACC_W(40), .SHIFT(15)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat4(input logic [31:0] d);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic beat2(input logic [31:0] d);
    b2.in_valid = 1'b1;
    b2.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    clear        = 1'b0;
    b4.in_valid  = 1'b0;
    b4.in_data   = '0;
    b4.out_ready = 1'b1;
    b2.in_valid  = 1'b0;
    b2.in_data   = '0;
    b2.out_ready = 1'b1;

    #12;
    chk("reset_out_valid", {31'b0, b4.out_valid}, 32'd0);
    chk("reset_out_data",  b4.out_data, 32'd0);
    chk("reset_out_sat",   {31'b0, b4.out_sat}, 32'd0);
    chk("reset_in_ready",  {31'b0, b4.in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic sum 1+2+3+4
    beat4(32'd1);
    beat4(32'd2);
    beat4(32'd3);
    chk("sum_not_yet_valid", {31'b0, b4.out_valid}, 32'd0);
    beat4(32'd4);
    chk("sum_valid", {31'b0, b4.out_valid}, 32'd1);
    chk("sum_data",  b4.out_data, 32'd10);
    chk("sum_sat",   {31'b0, b4.out_sat}, 32'd0);

    // Positive and negative saturation, back to back
    for (int i = 0; i < 4; i++) beat4(32'h7FFF_FFFF);
    chk("satpos_valid", {31'b0, b4.out_valid}, 32'd1);
    chk("satpos_data",  b4.out_data, 32'h7FFF_FFFF);
    chk("satpos_sat",   {31'b0, b4.out_sat}, 32'd1);
    for (int i = 0; i < 4; i++) beat4(32'h8000_0000);
    chk("satneg_data", b4.out_data, 32'h8000_0000);
    chk("satneg_sat",  {31'b0, b4.out_sat}, 32'd1);
    b4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'b0, b4.out_valid}, 32'd0);

    // Rounding at SHIFT=15
    beat2(32'h0000_2000);
    beat2(32'h0000_2000);
    chk("rnd_up_valid", {31'b0, b2.out_valid}, 32'd1);
    chk("rnd_up_data",  b2.out_data, 32'd1);
    chk("rnd_up_sat",   {31'b0, b2.out_sat}, 32'd0);
    beat2(32'hFFFF_FFFF);
    beat2(32'hFFFF_FFFE);
    chk("rnd_neg_data", b2.out_data, 32'd0);
    b2.in_valid = 1'b0;

    // Backpressure: hold sample A while sample B accumulates
    b4.out_ready = 1'b0;
    beat4(32'd1);
    beat4(32'd2);
    beat4(32'd3);
    beat4(32'd4);
    chk("bp_a_data", b4.out_data, 32'd10);
    b4.in_data = 32'd5;
    chk("bp_ready_b1", {31'b0, b4.in_ready}, 32'd1);
    beat4(32'd5);
    chk("bp_ready_b2", {31'b0, b4.in_ready}, 32'd1);
    beat4(32'd5);
    chk("bp_ready_b3", {31'b0, b4.in_ready}, 32'd1);
    beat4(32'd5);
    chk("bp_ready_b4", {31'b0, b4.in_ready}, 32'd0);
    beat4(32'd5);
    beat4(32'd5);
    chk("bp_hold_ready", {31'b0, b4.in_ready}, 32'd0);
    chk("bp_hold_data",  b4.out_data, 32'd10);
    chk("bp_hold_valid", {31'b0, b4.out_valid}, 32'd1);
    b4.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, b4.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    chk("bp_b_valid", {31'b0, b4.out_valid}, 32'd1);
    chk("bp_b_data",  b4.out_data, 32'd20);
    @(posedge clk);
    #1;

    // Clear mid-sample
    beat4(32'd1);
    beat4(32'd2);
    clear      = 1'b1;
    b4.in_data = 32'd99;
    #1;
    chk("clear_in_ready", {31'b0, b4.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) beat4(32'd7);
    chk("clear_data", b4.out_data, 32'd28);

    // Async reset with a pending sample and a partial sum
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat4(32'd1);
    for (int i = 0; i < 3; i++) beat4(32'd5);
    b4.in_valid = 1'b0;
    chk("rst_pre_valid", {31'b0, b4.out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, b4.out_valid}, 32'd0);
    chk("rst_async_data",  b4.out_data, 32'd0);
    @(negedge clk);
    reset_n      = 1'b1;
    b4.out_ready = 1'b1;
    beat4(32'd2);
    chk("rst_fresh_not_valid", {31'b0, b4.out_valid}, 32'd0);
    beat4(32'd2);
    beat4(32'd2);
    beat4(32'd2);
    b4.in_valid = 1'b0;
    chk("rst_fresh_valid", {31'b0, b4.out_valid}, 32'd1);
    chk("rst_fresh_data",  b4.out_data, 32'd8);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_accumulator.md
# fir_accumulator

Execute-stage back end of the FIR datapath. Takes the per-tap signed products produced by the ALU multiply operation and sums TAPS of them into one output sample. Each finished sum is rounded, arithmetically scaled down by SHIFT bits, saturated to 32 bits and offered on a valid/ready output port for writeback or the audio sink. A one-entry output register lets the next sample accumulate while the previous sample waits on backpressure.

## Interface
- TAPS, 8, products per output sample; 2 ≤ TAPS ≤ 2^(ACC_W−32)
- ACC_W, 40, accumulator width in bits; ≥ 33
- SHIFT, 15, arithmetic right shift applied to the final sum (Q15 scaling); 0 ≤ SHIFT ≤ ACC_W−2
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of the partial sum
- in_valid  in  1  product beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  32  signed product (ALU Result)
- out_valid  out  1  output sample present
- out_ready  in  1  consumer takes the sample when out_valid && out_ready
- out_data  out  32  signed rounded, scaled, saturated sample
- out_sat  out  1  high with out_valid when out_data was clipped

## Operation
- State machine: IDLE (accumulator empty, tap_cnt = 0) and ACCUM (1 ≤ tap_cnt ≤ TAPS−1).
- An accepted beat in IDLE loads acc = sext(in_data), sets tap_cnt = 1 and moves to ACCUM.
- An accepted beat in ACCUM with tap_cnt < TAPS−1 sets acc += sext(in_data) and increments tap_cnt.
- The final beat (tap_cnt = TAPS−1) computes total = acc + sext(in_data) and writes the output register. State returns to IDLE and tap_cnt wraps to 0.
- Output computation:
  - r = total + (SHIFT > 0 ? 2^(SHIFT−1) : 0), evaluated at ACC_W+1 bits.
  - q = r >>> SHIFT.
  - If q > 2^31−1: out_data = 0x7FFFFFFF, out_sat = 1.
  - If q < −2^31: out_data = 0x80000000, out_sat = 1.
  - Otherwise out_data = q[31:0], out_sat = 0.
- The accumulator cannot overflow within the TAPS bound. No intermediate saturation is applied.
- in_ready = !clear && !(tap_cnt == TAPS−1 && out_valid && !out_ready). Only the final beat is blocked, and only while the output slot is occupied and not draining.
- Drain and refill in the same cycle is allowed: the new sample replaces the old one and out_valid stays 1.
- clear: acc ← 0, tap_cnt ← 0, state ← IDLE. in_ready is 0 while clear is high, so no beat is consumed. A pending output sample is not affected.
- out_data and out_sat hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sat = 0, acc = 0, tap_cnt = 0, state = IDLE. in_ready reads 1 after reset because clear is low.
- Reset is asynchronous. Asserting it mid-sample discards the partial sum and any pending output immediately.
- Latency: out_valid rises on the clock edge that accepts the final beat (1 cycle after the beat is presented).
- Throughput: one beat per cycle. Back-to-back samples are sustained when out_ready = 1.
- in_ready is combinational from out_ready, out_valid, tap_cnt and clear. No other input-to-output combinational paths exist.

## Structure
- Package fir_pkg:
  - state enum fir_acc_state_t {IDLE, ACCUM}
  - constants SAT_MAX = 32'h7FFFFFFF and SAT_MIN = 32'h80000000
  - default TAPS/SHIFT values shared with the coefficient memory
- Sub-module fir_round_sat (combinational):
  - ACC_W-bit total in → round, shift, saturate → 32-bit data + sat flag
  - parameterised by ACC_W and SHIFT
  - instantiated once on the final-beat path

## Test plan
- TAPS=4, SHIFT=0, beats 1,2,3,4 with out_ready=1 → one cycle after beat 4: out_valid=1, out_data=10, out_sat=0.
- TAPS=4, SHIFT=0, four beats of 0x7FFFFFFF → out_data=0x7FFFFFFF, out_sat=1. Four beats of 0x80000000 → out_data=0x80000000, out_sat=1.
- TAPS=2, SHIFT=15:
  - beats 0x2000, 0x2000 → out_data=1 (rounded)
  - beats −1, −2 → (−3 + 0x4000) >>> 15 = 0
- TAPS=4, SHIFT=0, out_ready=0 after sample A (sum 10), second sample beats 5,5,5,5:
  - in_ready drops only at the 4th beat
  - out_data stays 10 until out_ready=1
  - the next edge then shows out_data=20
- Reset and clear mid-sample:
  - clear after 2 of 4 beats (1,2), then beats 7,7,7,7 → out_data=28
  - reset_n low after 3 beats → out_valid=0 immediately; the next 4 beats form a fresh sample.
